led_pattern: RTL and testbench
==============================

# led_pattern

Parametrised LED pattern generator for board-level status and bring-up. A prescaler divides the system clock into step ticks, and a selectable mode engine drives N_LEDS outputs with one of four patterns: binary count, Gray count, bouncing scanner or PWM breathing. It supersedes the fixed 4-LED free-running counter blinker, and adds run-time mode select, pause and a tick output for other logic.

## Interface
- N_LEDS, 4: number of LED outputs, ≥1.
- TICK_DIV, 2097152: clock cycles per pattern step, ≥2.
- PWM_W, 8: breathing duty and PWM counter width, ≥2.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset. Clears all state immediately; release is synchronous to clk.
- mode  in  2  requested mode: 0 binary, 1 Gray, 2 scanner, 3 breathe.
- mode_wr  in  1  single-cycle strobe; loads `mode`.
- pause  in  1  while high, the prescaler and step state hold. The PWM counter keeps running.
- leds  out  N_LEDS  registered LED drive, 1 = on.
- tick  out  1  registered one-cycle pulse per pattern step.
- cur_mode  out  2  active mode.

## Operation
- Reset values:
  - leds=0, tick=0, cur_mode=0.
  - Prescaler, step, scanner pos and PWM counter all =0.
  - Breathe duty=0.
  - Scanner dir=up, breathe dir=up.
- Prescaler:
  - Counts 0..TICK_DIV-1 while pause=0.
  - At the edge where it equals TICK_DIV-1, it wraps to 0, tick goes high for one cycle and step state advances on that same edge.
- Binary (mode 0): step increments modulo 2^N_LEDS. leds = step.
- Gray (mode 1): same step counter. leds = step ^ (step>>1).
- Scanner (mode 2):
  - leds = one-hot at pos.
  - pos sequence is 0,1,…,N_LEDS-1,N_LEDS-2,…,0,1,… Each endpoint is shown once per bounce; dir flips on the tick that reaches an endpoint.
  - N_LEDS=1: pos stays 0 and leds=1.
- Breathe (mode 3):
  - duty steps +1 per tick up to 2^PWM_W-1, then -1 down to 0, then repeats. No endpoint is repeated.
  - PWM counter is PWM_W bits and free-runs every cycle, wrapping at 2^PWM_W.
  - All leds = (pwm_cnt < duty). duty=0 means always off; maximum duty means on for 2^PWM_W-1 of every 2^PWM_W cycles.
- Mode write (mode_wr=1):
  - On that edge: cur_mode←mode, prescaler←0, step←0, pos←0, duty←0, both dirs←up, tick←0.
  - This applies even if the new mode equals the old one. It is legal while paused.
- Simultaneous events:
  - mode_wr with a prescaler wrap: mode_wr wins; no tick, no advance.
  - pause with a wrap: no wrap and no tick; the prescaler holds at TICK_DIV-1.
  - rst dominates everything at any time, including mid-pattern; outputs go to reset values without waiting for clk.

## Timing
- First tick: TICK_DIV rising edges after rst deasserts, with pause=0.
- Subsequent ticks are exactly TICK_DIV cycles apart while unpaused.
- Pause for P cycles delays all later ticks by exactly P cycles.
- leds is registered from step state, so leds reflects a new step one cycle after tick is high.
- cur_mode changes on the mode_wr edge.
- leds shows the new mode's initial pattern one cycle after the mode_wr edge: 0 for binary/Gray, 1 for scanner, off for breathe.
- Breathe output: leds changes within a PWM period, one cycle after the pwm_cnt compare changes.

## Test plan
All scenarios use N_LEDS=4, TICK_DIV=4, PWM_W=3.
- Reset release, mode 0, 20 cycles -> tick high on cycles 4,8,12,16,20; leds 0,1,2,3,4,5 each appearing one cycle after its tick. Run to 16 ticks -> leds wraps 15→0.
- mode_wr with mode=1, then 8 ticks -> leds 0,1,3,2,6,7,5,4 (Gray). A mode_wr coinciding with a wrap -> no tick, and the next tick arrives 4 cycles later.
- mode_wr with mode=2, 8 ticks -> leds 0001,0010,0100,1000,0100,0010,0001,0010. Repeat with N_LEDS=1 -> leds stays 1.
- mode_wr with mode=3 -> duty sequence 0..7..0 over 14 ticks. At duty=3, leds high for exactly 3 of every 8 cycles; at duty=0, leds never high.
- pause high for 5 cycles mid-count -> next tick 5 cycles late, leds value held. PWM counter still advances, verified via breathe duty cycle.
- Assert rst asynchronously mid-scan, between edges -> leds, tick and cur_mode go to 0 immediately. After release, the first tick is at cycle 4.

Source files
------------

// File: rtl/led_pattern.sv
// LED pattern generator: a prescaler produces step ticks that drive a binary,
// Gray, bouncing-scanner or PWM-breathing pattern on N_LEDS registered outputs.
module led_pattern #(
  parameter int N_LEDS   = 4,
  parameter int TICK_DIV = 2097152,
  parameter int PWM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              mode_wr,
  input  logic              pause,
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic [1:0]        cur_mode
);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int POS_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {M_BIN, M_GRAY, M_SCAN, M_BREATHE} mode_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [N_LEDS-1:0]  step_q, step_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               sdir_q, sdir_d;   // scanner direction, 0 = up
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic               bdir_q, bdir_d;   // breathe direction, 0 = up
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               tick_q, tick_d;
  mode_e              mode_q, mode_d;
  logic               wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
      pos_q   <= '0;
      sdir_q  <= 1'b0;
      duty_q  <= '0;
      bdir_q  <= 1'b0;
      pwm_q   <= '0;
      leds_q  <= '0;
      tick_q  <= 1'b0;
      mode_q  <= M_BIN;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      sdir_q  <= sdir_d;
      duty_q  <= duty_d;
      bdir_q  <= bdir_d;
      pwm_q   <= pwm_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    wrap    = !pause && (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d = presc_q;
    step_d  = step_q;
    pos_d   = pos_q;
    sdir_d  = sdir_q;
    duty_d  = duty_q;
    bdir_d  = bdir_q;
    pwm_d   = pwm_q + PWM_W'(1);
    tick_d  = wrap;
    mode_d  = mode_q;

    if (!pause) presc_d = wrap ? '0 : presc_q + PRESC_W'(1);

    // Every engine steps on every tick; only the active one is displayed.
    if (wrap) begin
      step_d = step_q + N_LEDS'(1);
      if (N_LEDS > 1) begin
        if (!sdir_q) begin
          pos_d = pos_q + POS_W'(1);
          if (pos_q == POS_W'(N_LEDS - 2)) sdir_d = 1'b1;
        end else begin
          pos_d = pos_q - POS_W'(1);
          if (pos_q == POS_W'(1)) sdir_d = 1'b0;
        end
      end
      if (!bdir_q) begin
        duty_d = duty_q + PWM_W'(1);
        if (duty_q == DUTY_MAX - PWM_W'(1)) bdir_d = 1'b1;
      end else begin
        duty_d = duty_q - PWM_W'(1);
        if (duty_q == PWM_W'(1)) bdir_d = 1'b0;
      end
    end

    // A mode write restarts the pattern and suppresses a coincident tick.
    if (mode_wr) begin
      mode_d  = mode_e'(mode);
      presc_d = '0;
      step_d  = '0;
      pos_d   = '0;
      sdir_d  = 1'b0;
      duty_d  = '0;
      bdir_d  = 1'b0;
      tick_d  = 1'b0;
    end

    case (mode_q)
      M_BIN:   leds_d = step_q;
      M_GRAY:  leds_d = step_q ^ (step_q >> 1);
      M_SCAN:  leds_d = N_LEDS'(1) << pos_q;
      default: leds_d = {N_LEDS{pwm_q < duty_q}};
    endcase
  end

  assign leds     = leds_q;
  assign tick     = tick_q;
  assign cur_mode = mode_q;
endmodule

// File: tb/tb_led_pattern.sv
// Directed bench for led_pattern (N_LEDS=4, TICK_DIV=4, PWM_W=3) plus an
// N_LEDS=1 instance sharing the same inputs for the single-LED scanner case.
module tb_led_pattern;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       mode_wr = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] leds;
  logic       tick;
  logic [1:0] cur_mode;
  logic [0:0] leds1;
  logic       tick1;
  logic [1:0] cm1;

  int checks = 0;
  int failures = 0;
  int cnt = 0;

  led_pattern #(.N_LEDS(4), .TICK_DIV(4), .PWM_W(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .mode_wr(mode_wr), .pause(pause),
    .leds(leds), .tick(tick), .cur_mode(cur_mode));

  led_pattern #(.N_LEDS(1), .TICK_DIV(4), .PWM_W(3)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .mode_wr(mode_wr), .pause(pause),
    .leds(leds1), .tick(tick1), .cur_mode(cm1));

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] md;
    logic       ps;
    logic       tk;
    logic [3:0] ld;
    logic [1:0] cm;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic wr, input logic [1:0] md, input logic ps,
                     input logic tk, input logic [3:0] ld, input logic [1:0] cm);
    vec_t v;
    v.wr = wr; v.md = md; v.ps = ps; v.tk = tk; v.ld = ld; v.cm = cm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cnt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic do_wr(input logic [1:0] m);
    mode = m;
    mode_wr = 1'b1;
    cyc();
    mode_wr = 1'b0;
  endtask

  task automatic next_tick(output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 20) begin
      cyc();
      n++;
      if (tick === 1'b1) begin
        at = cnt;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout no tick within 20 cycles (cycle %0d)", cnt);
    end
  endtask

  initial begin
    int t, t0, prev, on;
    int gexp[8];
    int sexp[8];
    int dexp[16];
    gexp = '{0, 1, 3, 2, 6, 7, 5, 4};
    sexp = '{1, 2, 4, 8, 4, 2, 1, 2};
    dexp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    // cycles 1..26 after reset release: binary count, then a Gray mode write
    add(0,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 1,0,0);
    add(0,0,0, 0,1,0); add(0,0,0, 0,1,0); add(0,0,0, 0,1,0); add(0,0,0, 1,1,0);
    add(0,0,0, 0,2,0); add(0,0,0, 0,2,0); add(0,0,0, 0,2,0); add(0,0,0, 1,2,0);
    add(0,0,0, 0,3,0); add(0,0,0, 0,3,0); add(0,0,0, 0,3,0); add(0,0,0, 1,3,0);
    add(0,0,0, 0,4,0); add(0,0,0, 0,4,0); add(0,0,0, 0,4,0); add(0,0,0, 1,4,0);
    add(1,1,0, 0,5,1); add(0,1,0, 0,0,1); add(0,1,0, 0,0,1); add(0,1,0, 0,0,1);
    add(0,1,0, 1,0,1); add(0,1,0, 0,1,1);

    repeat (2) cyc();
    chk("rst_leds", leds, 0);
    chk("rst_tick", tick, 0);
    chk("rst_mode", cur_mode, 0);
    chk("rst_leds1", leds1, 0);
    chk("rst_tick1", tick1, 0);
    chk("rst_mode1", cm1, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      mode_wr = vecs[i].wr; mode = vecs[i].md; pause = vecs[i].ps;
      cyc();
      chk($sformatf("vec%0d_tick", i), tick, vecs[i].tk);
      chk($sformatf("vec%0d_leds", i), leds, vecs[i].ld);
      chk($sformatf("vec%0d_mode", i), cur_mode, vecs[i].cm);
    end
    mode_wr = 1'b0;

    // binary wraps 15 -> 0 on the 16th tick
    do_wr(0);
    for (int k = 1; k <= 16; k++) begin
      next_tick(t);
      cyc();
      chk($sformatf("bin_step%0d", k), leds, k % 16);
    end

    // pause for 5 cycles delays the next tick by 5 and holds leds
    do_wr(0);
    next_tick(t);
    cyc();
    chk("pause_pre_leds", leds, 1);
    pause = 1'b1;
    repeat (5) cyc();
    chk("pause_hold_leds", leds, 1);
    chk("pause_no_tick", tick, 0);
    pause = 1'b0;
    next_tick(t0);
    chk("pause_tick_delay", t0 - t, 9);

    // Gray sequence with exact 4-cycle tick spacing
    do_wr(1);
    t0 = cnt;
    cyc();
    chk("gray_init", leds, 0);
    prev = t0;
    for (int k = 1; k < 8; k++) begin
      next_tick(t);
      chk($sformatf("gray_space%0d", k), t - prev, 4);
      prev = t;
      cyc();
      chk($sformatf("gray_step%0d", k), leds, gexp[k]);
    end

    // mode write on the wrap edge: no tick there, next tick 4 cycles later
    repeat (2) cyc();
    do_wr(1);
    chk("wrwrap_no_tick", tick, 0);
    chk("wrwrap_mode", cur_mode, 1);
    next_tick(t);
    chk("wrwrap_next_tick", t - prev, 8);

    // scanner bounce; single-LED instance stays lit
    do_wr(2);
    chk("scan_mode", cur_mode, 2);
    cyc();
    chk("scan_init", leds, sexp[0]);
    chk("scan1_init", leds1, 1);
    for (int k = 1; k < 8; k++) begin
      next_tick(t);
      cyc();
      chk($sformatf("scan_step%0d", k), leds, sexp[k]);
      chk($sformatf("scan1_step%0d", k), leds1, 1);
    end

    // asynchronous reset between edges, mid-scan
    #3;
    rst = 1'b1;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_tick", tick, 0);
    chk("arst_mode", cur_mode, 0);
    repeat (2) cyc();
    rst = 1'b0;
    t0 = cnt;
    next_tick(t);
    chk("arst_first_tick", t - t0, 4);
    chk("arst_mode_after", cur_mode, 0);

    // breathe: freeze each duty with pause and count on-cycles over 8 cycles
    do_wr(3);
    cyc();
    cyc();
    chk("breathe_init_a", leds, 0);
    cyc();
    chk("breathe_init_b", leds, 0);
    for (int k = 1; k <= 15; k++) begin
      next_tick(t);
      pause = 1'b1;
      cyc();
      on = 0;
      for (int j = 0; j < 8; j++) begin
        cyc();
        if (leds == 4'hF) on++;
        else if (leds != 4'h0) chk($sformatf("breathe_uniform%0d", k), leds, 0);
      end
      pause = 1'b0;
      chk($sformatf("breathe_duty%0d", k), on, dexp[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule
